sseg_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It holds a double-buffered 8-nibble display word and walks one digit at a time through the anodes. Each scan step presents the selected nibble to the downstream BCD-to-cathode decoder, with a blanking gap between digits to suppress ghosting. It sits between the application logic (counters, BCD converters) and the display pins.

---
 rtl/sseg_scan_controller.sv | 144 ++++++++++++++
 tb/tb_sseg_scan_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Double-buffers the display word and walks one digit at a time with optional blanking gaps.
module sseg_scan_controller #(
    parameter int NUM_DIGITS      = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 2000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    input  logic                    lzs,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   sseg_anode,
    output logic [3:0]              digit,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int MAX_TICKS = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {SHOW, BLANK} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    first_cycle;

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_en;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic                    pend_valid;

    logic                    step_end;
    logic                    wrap;
    logic                    transfer;
    logic [IDX_W-1:0]        next_idx;
    logic [NUM_DIGITS-1:0]   suppressed;
    logic [NUM_DIGITS-1:0]   anode_sel;
    logic                    lit;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        step_end   = 1'b0;
        suppressed = '0;
        if (state == SHOW)
            step_end = (cnt == SHOW_LAST) && (BLANK_TICKS == 0);
        else
            step_end = (cnt == BLANK_LAST);
        wrap      = step_end && (idx == IDX_LAST);
        transfer  = (wrap || first_cycle) && pend_valid;
        next_idx  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        // A digit is blanked when it and every more-significant active nibble is zero.
        for (int i = 1; i < NUM_DIGITS; i++)
            suppressed[i] = lzs && ((act_value >> (4 * i)) == '0);
        anode_sel = ~(NUM_DIGITS'(1) << idx);
        lit       = act_en[idx] && !suppressed[idx];
    end

    // NOTE: sequential state uses non-blocking assignments only; the display buffers are
    // real registers (not a RAM) and are cleared by reset so the display starts dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SHOW;
            cnt         <= '0;
            idx         <= '0;
            first_cycle <= 1'b1;
            act_value   <= '0;
            act_dp      <= '0;
            act_en      <= '0;
            pend_value  <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_valid  <= 1'b0;
            sseg_anode  <= '1;
            digit       <= '0;
            dp_n        <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            first_cycle <= 1'b0;
            frame_done  <= wrap;

            if (transfer) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
            end

            // A load coinciding with a transfer is kept for the following frame.
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_en    <= digit_enable;
                pend_valid <= 1'b1;
            end else if (transfer) begin
                pend_valid <= 1'b0;
            end

            case (state)
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt <= '0;
                        if (BLANK_TICKS == 0)
                            idx <= next_idx;
                        else
                            state <= BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        idx   <= next_idx;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SHOW;
            endcase

            // Outputs reflect the pre-edge state/idx; digit and dp_n hold through blanking.
            if (state == SHOW) begin
                sseg_anode <= lit ? anode_sel : '1;
                digit      <= act_value[4*int'(idx) +: 4];
                dp_n       <= ~act_dp[idx];
            end else begin
                sseg_anode <= '1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Scoreboard bench: two scan controllers (with and without blanking) share randomized stimulus;
// a frame-level reference model predicts every cycle's outputs and a monitor compares them.
module tb_sseg_scan_controller;

    localparam int ND = 8;
    localparam int T0 = 4;
    localparam int B0 = 1;
    localparam int T1 = 3;
    localparam int B1 = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   value = '0;
    logic [7:0]    dp_in = '0;
    logic [7:0]    digit_enable = '0;
    logic          lzs = 1'b0;
    logic          load = 1'b0;

    logic [7:0]    an0, an1;
    logic [3:0]    dig0, dig1;
    logic          dpn0, dpn1, fd0, fd1;

    sseg_scan_controller #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T0), .BLANK_TICKS(B0)) dut0 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_enable(digit_enable),
        .lzs(lzs), .load(load), .sseg_anode(an0), .digit(dig0), .dp_n(dpn0), .frame_done(fd0)
    );

    sseg_scan_controller #(.NUM_DIGITS(ND), .TICKS_PER_DIGIT(T1), .BLANK_TICKS(B1)) dut1 (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .digit_enable(digit_enable),
        .lzs(lzs), .load(load), .sseg_anode(an1), .digit(dig1), .dp_n(dpn1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [31:0] v;
        logic [7:0]  dp;
        logic [7:0]  en;
    } load_t;

    typedef logic [13:0] obs_t;  // {anode, digit, dp_n, frame_done}

    load_t loads[$];
    obs_t  q0[$];
    obs_t  q1[$];
    int    k = 0;
    int    total = 0;
    int    bad = 0;

    localparam obs_t RESET_OBS = {8'hFF, 4'h0, 1'b1, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: a frame shows the newest load issued at least two cycles before its start
    // edge; within a frame each digit is lit for t cycles then dark for b cycles.
    function automatic obs_t model(input int kk, input int t, input int b, input logic lz);
        int          p   = t + b;
        int          fp  = ND * p;
        int          f   = kk / fp;
        int          pos = kk % fp;
        int          d   = pos / p;
        bit          show = (pos % p) < t;
        logic [31:0] v  = '0;
        logic [7:0]  dp = '0;
        logic [7:0]  en = '0;
        logic [3:0]  nib;
        logic [7:0]  an;
        bit          sup;
        foreach (loads[i]) begin
            if (loads[i].k <= f * fp - 2) begin
                v  = loads[i].v;
                dp = loads[i].dp;
                en = loads[i].en;
            end
        end
        nib = v[4*d +: 4];
        sup = lz && (d != 0) && ((v >> (4 * d)) == 32'h0);
        an  = (show && en[d] && !sup) ? ~(8'(1) << d) : 8'hFF;
        return {an, nib, ~dp[d], pos == fp - 1};
    endfunction

    // Expectation producer: one prediction per clock edge for each DUT.
    always @(posedge clk) begin
        if (reset) begin
            loads.delete();
            k = 0;
            q0.push_back(RESET_OBS);
            q1.push_back(RESET_OBS);
        end else begin
            q0.push_back(model(k, T0, B0, lzs));
            q1.push_back(model(k, T1, B1, lzs));
            if (load) loads.push_back('{k, value, dp_in, digit_enable});
            k++;
        end
    end

    // Monitor: outputs are stable between the posedge and the next negedge.
    always @(negedge clk) begin
        if (q0.size() == 0 || q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty at %0t: got no prediction expected one", $time);
        end else begin
            check("dut0_outputs", 32'({an0, dig0, dpn0, fd0}), 32'(q0.pop_front()));
            check("dut1_outputs", 32'({an1, dig1, dpn1, fd1}), 32'(q1.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
        value        = v;
        dp_in        = dp;
        digit_enable = en;
        load         = 1'b1;
        cyc(1);
        load         = 1'b0;
    endtask

    task automatic frame_period(input int which, input int exp);
        int c = 0;
        int first = -1;
        int gap = -1;
        for (int i = 0; i < 200 && gap < 0; i++) begin
            cyc(1);
            c++;
            if ((which == 0) ? fd0 : fd1) begin
                if (first < 0) first = c;
                else gap = c - first;
            end
        end
        if (gap < 0) begin
            total++;
            bad++;
            $display("FAIL frame_period%0d: got timeout expected %0d", which, exp);
        end else begin
            check(which == 0 ? "frame_period0" : "frame_period1", 32'(gap), 32'(exp));
        end
    endtask

    task automatic wait_pos(input int frame_len, input int target);
        int guard = 0;
        while ((k % frame_len) != target && guard < 400) begin
            cyc(1);
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;

        // Dark display with no load; frame_done cadence from both configurations.
        cyc(200);
        frame_period(0, ND * (T0 + B0));
        frame_period(1, ND * (T1 + B1));

        // Plain scan of a full word.
        do_load(32'h12345678, 8'h00, 8'hFF);
        cyc(100);

        // Leading-zero suppression with a decimal point on a zero digit.
        lzs = 1'b1;
        do_load(32'h00000305, 8'h02, 8'hFF);
        cyc(100);

        // Two loads inside one frame: the later one wins at the next boundary.
        lzs = 1'b0;
        wait_pos(ND * (T0 + B0), 16);
        do_load(32'hAAAAAAAA, 8'h00, 8'hFF);
        cyc(1);
        do_load(32'h11111111, 8'h00, 8'hFF);
        cyc(100);

        // Asynchronous reset in the middle of digit 5.
        wait_pos(ND * (T0 + B0), 26);
        reset = 1'b1;
        #1;
        check("reset_anode0", 32'(an0), 32'hFF);
        check("reset_anode1", 32'(an1), 32'hFF);
        check("reset_digit0", 32'(dig0), 32'h0);
        check("reset_dpn0", 32'(dpn0), 32'h1);
        check("reset_fd0", 32'(fd0), 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(60);
        do_load(32'h87654321, 8'h81, 8'hF7);
        cyc(100);

        // Randomized loads, enables, decimal points and suppression.
        for (int i = 0; i < 30; i++) begin
            cyc($urandom_range(1, 60));
            lzs = 1'($urandom_range(0, 1));
            do_load($urandom >> (4 * $urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        cyc(120);
        frame_period(0, ND * (T0 + B0));
        frame_period(1, ND * (T1 + B1));

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
